// File: rtl/tpu_run_sequencer_if.sv
// -----------------------------------------------------------------------------
// tpu_run_sequencer_if
// Groups the host start interface and the UB / weight-FIFO / systolic-array /
// result-SRAM control signals of the TPU run sequencer.
//
//   start             host -> seq   run request (sampled only while idle)
//   ub_base           host -> seq   first activation row address
//   num_rows          host -> seq   number of activation rows (0..2^ADDRESSSIZE)
//   res_base          host -> seq   first result-SRAM address
//   fifo_empty        fifo -> seq   weight FIFO empty flag
//   fifo_read_enable  seq  -> fifo  one-cycle pop of the weight FIFO
//   we_rl             seq  -> array weight reload
//   ub_addr           seq  -> UB    activation row read address
//   act_valid         seq  -> UB    ub_addr carries a live row
//   res_we            seq  -> SRAM  result write enable
//   res_addr          seq  -> SRAM  result write address
//   busy, done        seq  -> host  status / one-cycle completion pulse
//   busy_cycles, stall_cycles       only when SEQ_PERF_CNT_EN is defined
//
// Modports: master = host/environment side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface tpu_run_sequencer_if #(
  parameter int ADDRESSSIZE = 10
);
  logic                   start;
  logic [ADDRESSSIZE-1:0] ub_base;
  logic [ADDRESSSIZE:0]   num_rows;
  logic [ADDRESSSIZE-1:0] res_base;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   we_rl;
  logic [ADDRESSSIZE-1:0] ub_addr;
  logic                   act_valid;
  logic                   res_we;
  logic [ADDRESSSIZE-1:0] res_addr;
  logic                   busy;
  logic                   done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]            busy_cycles;
  logic [31:0]            stall_cycles;
`endif

  modport master (
    output start, ub_base, num_rows, res_base, fifo_empty,
    input  fifo_read_enable, we_rl, ub_addr, act_valid, res_we, res_addr,
           busy, done
`ifdef SEQ_PERF_CNT_EN
    , input busy_cycles, stall_cycles
`endif
  );

  modport slave (
    input  start, ub_base, num_rows, res_base, fifo_empty,
    output fifo_read_enable, we_rl, ub_addr, act_valid, res_we, res_addr,
           busy, done
`ifdef SEQ_PERF_CNT_EN
    , output busy_cycles, stall_cycles
`endif
  );
endinterface

// File: rtl/tpu_run_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_run_sequencer
// Runs one matrix-multiply pass of the 8x8 TPU datapath: pops a weight set,
// holds weight reload for WLOAD_CYC cycles, streams num_rows activation row
// addresses into the UB, writes each result row RESULT_LAT cycles after its
// address issue, then pulses done.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - tpu_run_sequencer_if.slave (host, UB, FIFO, array, result SRAM)
//
// Every output is registered and is a decode of the state one cycle earlier.
//
// Optional feature: define SEQ_PERF_CNT_EN to add the busy_cycles and
// stall_cycles performance counters.
// -----------------------------------------------------------------------------
module tpu_run_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int WLOAD_CYC   = 8,
  parameter int RESULT_LAT  = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  tpu_run_sequencer_if.slave      bus
);

  localparam int CNTW = ADDRESSSIZE + 1;
  localparam int WCW  = $clog2(WLOAD_CYC + 1);
  // res_we itself is the last stage of the RESULT_LAT-deep delay line.
  localparam int DLYW = RESULT_LAT - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_REQ,
    S_W_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_fifo_re;
  logic                   w_we_rl;
  logic                   w_act_valid;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_drain_clear;

  logic [ADDRESSSIZE-1:0] r_ub_ptr;
  logic [CNTW-1:0]        r_rows_left;
  logic [WCW-1:0]         r_wcnt;
  logic [DLYW-1:0]        r_dly;

  logic                   r_fifo_re;
  logic                   r_we_rl;
  logic [ADDRESSSIZE-1:0] r_ub_addr;
  logic                   r_act_valid;
  logic                   r_res_we;
  logic [ADDRESSSIZE-1:0] r_res_addr;
  logic                   r_busy;
  logic                   r_done;

  // The last row can leave DRAIN once it is in the final delay stage: nothing
  // is left upstream of it, so res_we fires next cycle and done the one after.
  assign w_drain_clear = !r_act_valid && (r_dly[DLYW-2:0] == '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fifo_re   = 1'b0;
    w_we_rl     = 1'b0;
    w_act_valid = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.num_rows == '0) ? S_DONE : S_W_REQ;
        end
      end
      S_W_REQ: begin
        if (!bus.fifo_empty) begin
          w_fifo_re   = 1'b1;
          w_state_nxt = S_W_LOAD;
        end
      end
      S_W_LOAD: begin
        w_we_rl = 1'b1;
        if (r_wcnt == WCW'(WLOAD_CYC - 1)) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_act_valid = 1'b1;
        if (r_rows_left == CNTW'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_clear) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      // The delay line is cleared too, which discards in-flight result writes.
      r_state     <= S_IDLE;
      r_ub_ptr    <= '0;
      r_rows_left <= '0;
      r_wcnt      <= '0;
      r_dly       <= '0;
      r_fifo_re   <= 1'b0;
      r_we_rl     <= 1'b0;
      r_ub_addr   <= '0;
      r_act_valid <= 1'b0;
      r_res_we    <= 1'b0;
      r_res_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fifo_re   <= w_fifo_re;
      r_we_rl     <= w_we_rl;
      r_act_valid <= w_act_valid;
      r_busy      <= w_busy;
      r_done      <= w_done;

      r_wcnt <= (r_state == S_W_LOAD) ? r_wcnt + 1'b1 : '0;

      if (r_state == S_STREAM) begin
        r_ub_addr   <= r_ub_ptr;
        r_ub_ptr    <= r_ub_ptr + 1'b1;
        r_rows_left <= r_rows_left - 1'b1;
      end

      r_dly    <= {r_dly[DLYW-2:0], r_act_valid};
      r_res_we <= r_dly[DLYW-1];
      if (r_res_we) r_res_addr <= r_res_addr + 1'b1;

      if (w_accept) begin
        r_ub_ptr    <= bus.ub_base;
        r_rows_left <= bus.num_rows;
        r_res_addr  <= bus.res_base;
      end
    end
  end

  assign bus.fifo_read_enable = r_fifo_re;
  assign bus.we_rl            = r_we_rl;
  assign bus.ub_addr          = r_ub_addr;
  assign bus.act_valid        = r_act_valid;
  assign bus.res_we           = r_res_we;
  assign bus.res_addr         = r_res_addr;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_busy_cycles;
  logic [31:0] r_stall_cycles;

  // Counters restart with each accepted run, saturate, and hold while idle
  // because neither increment condition can be true there.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_busy_cycles  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_busy && (r_busy_cycles != '1)) r_busy_cycles <= r_busy_cycles + 1'b1;
      if ((r_state == S_W_REQ) && bus.fifo_empty && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.busy_cycles  = r_busy_cycles;
  assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/tpu_run_sequencer.md
Name: tpu_run_sequencer

Overview:
Controller that runs one matrix-multiply pass of the 8x8 TPU datapath.
- Pops one weight set from the weight FIFO and pulses weight reload on the systolic array.
- Streams activation-row addresses into the unified buffer.
- Writes each result row into the result SRAM at a fixed pipeline latency, then signals completion.
- Sits between the host start interface and the UB, FIFO, systolic-array and result-SRAM ports.

Parameters:
ADDRESSSIZE, 10, width of UB and result-SRAM addresses
WLOAD_CYC, 8, cycles we_rl is held high per weight load (one per PE row)
RESULT_LAT, 17, cycles from ub_addr issue to the matching result row being valid at the result-SRAM input

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  run request; sampled only in IDLE
ub_base  in  ADDRESSSIZE  first activation row address
num_rows  in  ADDRESSSIZE+1  number of activation rows (0..1024)
res_base  in  ADDRESSSIZE  first result-SRAM address
fifo_empty  in  1  weight FIFO empty flag
fifo_read_enable  out  1  one-cycle pop of the weight FIFO
we_rl  out  1  systolic-array weight reload
ub_addr  out  ADDRESSSIZE  UB read address
act_valid  out  1  ub_addr carries a live row this cycle
res_we  out  1  result-SRAM write enable
res_addr  out  ADDRESSSIZE  result-SRAM write address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. Reset values: every output is 0. State is IDLE, delay line and counters are cleared.
- IDLE:
  - start=1 latches ub_base, num_rows and res_base.
  - If num_rows=0, go to DONE. Otherwise go to W_REQ.
- W_REQ:
  - While fifo_empty=1, wait with no outputs active except busy.
  - When fifo_empty=0, drive fifo_read_enable=1 for exactly one cycle and go to W_LOAD.
- W_LOAD:
  - we_rl=1 for exactly WLOAD_CYC consecutive cycles, then go to STREAM.
- STREAM:
  - For i = 0..num_rows-1, one row per cycle with no gaps: act_valid=1 and ub_addr = (ub_base+i) mod 2^ADDRESSSIZE.
  - After the last row, go to DRAIN.
- Delay line:
  - act_valid feeds a RESULT_LAT-deep 1-bit shift register. Its output drives res_we.
  - res_addr starts at res_base and increments mod 2^ADDRESSSIZE after each res_we.
  - Row i is written at res_base+i, exactly RESULT_LAT cycles after its ub_addr issue.
- DRAIN:
  - Hold until the delay line is all zero and the last res_we has been issued, then go to DONE.
- DONE:
  - done=1 for one cycle, busy still 1. Next cycle return to IDLE, with busy=0.
- Boundary conditions:
  - start while busy: ignored, latched parameters unchanged.
  - start held high: a new run begins on the first IDLE cycle after DONE.
  - num_rows=0: no FIFO pop, no we_rl, no act_valid, no res_we. done pulses 2 cycles after start.
  - Address wrap: 0x3FF is followed by 0x000 on both ub_addr and res_addr.
  - rst mid-run: aborts at the next edge. All outputs drop to 0. In-flight res_we pulses are discarded.
  - fifo_empty going 1 during W_LOAD or STREAM has no effect; only W_REQ checks it.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined:
  - Adds output busy_cycles [31:0], which counts cycles with busy=1.
  - Adds output stall_cycles [31:0], which counts W_REQ cycles with fifo_empty=1.
  - Both counters clear on rst and on each accepted start, saturate at 0xFFFFFFFF, and hold their value in IDLE.
- Undefined: neither port exists, and no counter logic is built.

Test Plan:
- Basic run: fifo_empty=0, start with ub_base=0x010, num_rows=8, res_base=0x040.
  - Required: one fifo_read_enable pulse, then we_rl high 8 cycles.
  - Required: ub_addr 0x010..0x017 on 8 consecutive cycles.
  - Required: res_we at 0x040..0x047, each 17 cycles after its issue. done 1 cycle after the last res_we; busy falls the cycle after.
- FIFO stall: fifo_empty=1 for 5 cycles after start.
  - Required: stay in W_REQ with no pops for those 5 cycles. fifo_read_enable on the first cycle fifo_empty=0; the remaining sequence matches the basic run.
  - With SEQ_PERF_CNT_EN: stall_cycles=5.
- Wrap: ub_base=0x3FE, res_base=0x3FF, num_rows=4.
  - Required: ub_addr 0x3FE, 0x3FF, 0x000, 0x001. res_addr 0x3FF, 0x000, 0x001, 0x002.
- Zero rows: num_rows=0.
  - Required: done 2 cycles after start; fifo_read_enable, we_rl, act_valid and res_we never asserted.
- Start while busy: second start pulse with ub_base=0x100 during STREAM.
  - Required: ignored; addresses continue from the original ub_base, and exactly one done pulse.
- Reset mid-run: rst for 1 cycle at the 3rd STREAM cycle.
  - Required: next cycle all outputs are 0 and state is IDLE. No res_we afterwards. A new start then runs normally.
